// File: rtl/lr_sc_reservation.sv
// LR/SC reservation tracker: one reservation granule, same-cycle SC decision, SC write gating.
// Optional macro LR_SC_TIMEOUT_EN builds the reservation timeout counter.
module lr_sc_reservation #(
    parameter int ADDR_WIDTH   = 32,
    parameter int GRANULE_BITS = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic                  atomic_flag,
    input  logic                  is_sc,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  snoop_valid,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    output logic                  reserved_flag,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic                  sc_success,
    output logic                  mem_write_gated
);

    typedef enum logic {IDLE, HELD} state_t;

    state_t state;
    logic   lr_ev;
    logic   sc_ev;
    logic   st_ev;
    logic   snp_res_hit;
    logic   snp_addr_hit;
    logic   st_res_hit;
    logic   timeout_hit;
    logic   unused_low_bits;

    function automatic logic same_granule(input logic [ADDR_WIDTH-1:0] a,
                                          input logic [ADDR_WIDTH-1:0] b);
        return a[ADDR_WIDTH-1:GRANULE_BITS] == b[ADDR_WIDTH-1:GRANULE_BITS];
    endfunction

    assign lr_ev        = valid & atomic_flag & ~is_sc;
    assign sc_ev        = valid & atomic_flag & is_sc;
    assign st_ev        = valid & mem_write & ~atomic_flag;
    assign snp_res_hit  = snoop_valid & same_granule(snoop_addr, res_addr);
    assign snp_addr_hit = snoop_valid & same_granule(snoop_addr, addr);
    assign st_res_hit   = st_ev & same_granule(addr, res_addr);

    assign reserved_flag   = (state == HELD);
    assign sc_success      = sc_ev & reserved_flag & same_granule(addr, res_addr) & ~snp_addr_hit;
    assign mem_write_gated = mem_write & ~(sc_ev & ~sc_success);

    // Granule offset bits never take part in any compare.
    assign unused_low_bits = ^{addr[GRANULE_BITS-1:0], snoop_addr[GRANULE_BITS-1:0]};

`ifdef LR_SC_TIMEOUT_EN
    localparam int              CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] age;

    always_ff @(posedge clk) begin
        if (reset) begin
            age <= '0;
        end else if (lr_ev) begin
            age <= '0;
        end else if (state == HELD) begin
            age <= age + 1'b1;
        end
    end

    assign timeout_hit = (state == HELD) && (age == LAST);
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
`endif

    // Priority: reset, snoop kill, LR/SC, own store, timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            res_addr <= '0;
        end else if (state == HELD && snp_res_hit) begin
            state <= IDLE;
        end else if (lr_ev) begin
            if (snp_addr_hit) begin
                state <= IDLE;
            end else begin
                state    <= HELD;
                res_addr <= {addr[ADDR_WIDTH-1:GRANULE_BITS], {GRANULE_BITS{1'b0}}};
            end
        end else if (sc_ev) begin
            state <= IDLE;
        end else if (state == HELD && st_res_hit) begin
            state <= IDLE;
        end else if (timeout_hit) begin
            state <= IDLE;
        end
    end

endmodule
